mult_sequencer: RTL and testbench
=================================

Name: mult_sequencer

Overview:
- Top-level controller for the multiplier datapath.
- Collects two signed 8-bit operands from the 4-bit dipswitch, one nibble per load press, then launches the multiplier and waits for its result.
- Holds the 16-bit product and hands it to sign_magnitude with a valid strobe, then waits for the binary_BCD ready flag before re-arming.
- Sits between the dipswitch/button inputs and the multiplier → sign_magnitude → binary_BCD → display_multiplexer chain. Runs on clk, not on clk_display.

Parameters:
- OP_WIDTH, 8, operand width; must be 2 × dipswitch width.
- TIMEOUT_CYCLES, 64, maximum clk cycles to wait for mult_done or BCD_ready before flagging an error.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- dipswitch  input  4  operand nibble entry
- load_btn  input  1  debounced, synchronous level; a rising edge = one load event
- mult_done  input  1  multiplier result valid, 1-cycle pulse
- mult_result  input  2*OP_WIDTH  multiplier product, two's complement
- BCD_ready  input  1  binary_BCD conversion complete, level or pulse
- operand_a  output  OP_WIDTH  multiplicand to multiplier
- operand_b  output  OP_WIDTH  multiplier operand
- mult_start  output  1  1-cycle start pulse to multiplier
- result  output  2*OP_WIDTH  latched product, feeds sign_magnitude mult_result
- result_valid  output  1  1-cycle valid pulse to sign_magnitude
- busy  output  1  high from S_START through S_CONVERT
- error  output  1  sticky timeout flag
- phase  output  3  current state encoding, for LEDs/debug

Behaviour:
- Reset (synchronous, active-high): state=S_A_LO; operand_a, operand_b, result = 0; mult_start, result_valid, busy, error = 0; edge-detect register = 0; timeout counter = 0.
- load_ev = load_btn & ~load_btn_q, where load_btn_q is registered every cycle. A held button produces exactly one event.
- Entry states, each advancing on load_ev:
  - S_A_LO: operand_a[3:0] <= dipswitch → S_A_HI.
  - S_A_HI: operand_a[7:4] <= dipswitch → S_B_LO.
  - S_B_LO: operand_b[3:0] <= dipswitch → S_B_HI.
  - S_B_HI: operand_b[7:4] <= dipswitch → S_START.
- S_START: mult_start=1 for exactly one cycle; counter cleared → S_WAIT_MULT.
- S_WAIT_MULT:
  - On mult_done: result <= mult_result → S_CONVERT. result_valid=1 on the first S_CONVERT cycle only.
  - Else counter++. When counter reaches TIMEOUT_CYCLES-1 → error<=1 → S_A_LO.
- S_CONVERT:
  - Wait for BCD_ready. The wait covers the sign_magnitude and binary_BCD latency; counter is restarted on entry.
  - On BCD_ready → S_SHOW.
  - On timeout → error<=1 → S_SHOW.
- S_SHOW:
  - result and operands hold, so the display stays stable.
  - On load_ev: operand_a, operand_b ← 0 → S_A_LO. result keeps its value until the next mult_done.
  - error clears on this load_ev.
- load_ev during S_START/S_WAIT_MULT/S_CONVERT is ignored; busy is high in these states.
- mult_done arriving in the same cycle as the timeout terminal count: mult_done wins, no error.
- mult_done outside S_WAIT_MULT is ignored; result is not updated.
- mult_start and result_valid are never high in the same cycle, and never high for 2 consecutive cycles.
- Latency:
  - Final load_ev → mult_start: 2 cycles (edge register, then S_START).
  - mult_done → result_valid: 1 cycle.
- Reset asserted mid-operation aborts immediately to the reset values; a pending mult_done is dropped.
- Arithmetic: no math in this block. Operands are passed as raw two's complement bits; result width is 2*OP_WIDTH.
- phase encoding: S_A_LO=0, S_A_HI=1, S_B_LO=2, S_B_HI=3, S_START=4, S_WAIT_MULT=5, S_CONVERT=6, S_SHOW=7.

Decomposition:
- Package mult_pkg: state enum seq_state_t (3-bit, encoding as above); localparam OP_WIDTH default; localparam RESULT_WIDTH = 2*OP_WIDTH.
- One natural sub-module: edge_detect (registered rising-edge pulse with synchronous reset), reusable for other button inputs.
- Timeout counter and FSM stay inline.

Test Plan:
- Load nibbles 3,0,5,0 (A=3, B=5); multiplier model returns 15 with mult_done 4 cycles after mult_start → expect:
  - exactly one mult_start;
  - result=16'h000F;
  - result_valid 1 cycle after mult_done;
  - BCD_ready → phase=7.
- A=8'hFD (−3), B=8'h05; model returns 16'hFFF1 → result=16'hFFF1, error=0, busy high from S_START through S_CONVERT.
- Hold load_btn high for 20 cycles in S_A_LO → only operand_a[3:0] is loaded; phase=1, not beyond.
- Model never asserts mult_done → after TIMEOUT_CYCLES cycles: error=1, phase=0. A subsequent full sequence runs normally and the next load in S_SHOW clears error.
- mult_done coincident with the timeout terminal count → result captured, error=0, phase=6.
- Assert reset during S_WAIT_MULT, then pulse mult_done → all outputs 0, phase=0, result not updated.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared types and constants for the multiplier sequencer slice.
//   seq_state_t : 3-bit sequencer state, value doubles as the phase LED code
//   is_busy()   : true while a multiplication/conversion is in flight
package mult_pkg;

    localparam int unsigned DIP_WIDTH      = 4;
    localparam int unsigned OP_WIDTH       = 2 * DIP_WIDTH;
    localparam int unsigned RESULT_WIDTH   = 2 * OP_WIDTH;
    localparam int unsigned TIMEOUT_CYCLES = 64;

    typedef enum logic [2:0] {
        S_A_LO      = 3'd0,
        S_A_HI      = 3'd1,
        S_B_LO      = 3'd2,
        S_B_HI      = 3'd3,
        S_START     = 3'd4,
        S_WAIT_MULT = 3'd5,
        S_CONVERT   = 3'd6,
        S_SHOW      = 3'd7
    } seq_state_t;

    function automatic logic is_busy(input seq_state_t s);
        return (s == S_START) || (s == S_WAIT_MULT) || (s == S_CONVERT);
    endfunction

endpackage

// File: rtl/mult_sequencer_edge_detect.sv
// Registered rising-edge detector for a synchronous, debounced level.
//   clk, reset : clock and synchronous active-high reset
//   sig        : input level
//   pulse      : one-cycle pulse, one cycle after sig rises
module edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic sig,
    output logic pulse
);

    logic sig_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sig_q <= 1'b0;
            pulse <= 1'b0;
        end else begin
            sig_q <= sig;
            pulse <= sig & ~sig_q;
        end
    end

endmodule

// File: rtl/mult_sequencer.sv
// Multiplier front-end controller: collects two operands nibble by nibble
// from the dipswitch, launches the multiplier, latches the product, strobes
// it towards sign_magnitude and waits for binary_BCD before re-arming.
//   dipswitch/load_btn           : operand entry (one nibble per press)
//   operand_a/b, mult_start      : multiplier request
//   mult_done, mult_result       : multiplier response
//   result, result_valid         : latched product to sign_magnitude
//   BCD_ready                    : conversion done from binary_BCD
//   busy, error, phase           : status / LEDs
module mult_sequencer #(
    parameter int unsigned OP_WIDTH       = mult_pkg::OP_WIDTH,
    parameter int unsigned TIMEOUT_CYCLES = mult_pkg::TIMEOUT_CYCLES
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [mult_pkg::DIP_WIDTH-1:0]  dipswitch,
    input  logic                            load_btn,
    input  logic                            mult_done,
    input  logic [2*OP_WIDTH-1:0]           mult_result,
    input  logic                            BCD_ready,
    output logic [OP_WIDTH-1:0]             operand_a,
    output logic [OP_WIDTH-1:0]             operand_b,
    output logic                            mult_start,
    output logic [2*OP_WIDTH-1:0]           result,
    output logic                            result_valid,
    output logic                            busy,
    output logic                            error,
    output logic [2:0]                      phase
);

    import mult_pkg::*;

    localparam int unsigned RES_W = 2 * OP_WIDTH;
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    seq_state_t          state_q, state_d;
    logic                load_ev;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                timeout_hit;
    logic [OP_WIDTH-1:0] operand_a_d, operand_b_d;
    logic [RES_W-1:0]    result_d;
    logic                error_d, mult_start_d, result_valid_d, busy_d;

    // Load button edge: a held button yields a single event.
    edge_detect u_load_edge (
        .clk   (clk),
        .reset (reset),
        .sig   (load_btn),
        .pulse (load_ev)
    );

    assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    assign phase       = state_q;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_A_LO;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; mult_done takes priority over a coincident timeout.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_A_LO:      if (load_ev) state_d = S_A_HI;
            S_A_HI:      if (load_ev) state_d = S_B_LO;
            S_B_LO:      if (load_ev) state_d = S_B_HI;
            S_B_HI:      if (load_ev) state_d = S_START;
            S_START:     state_d = S_WAIT_MULT;
            S_WAIT_MULT: begin
                if (mult_done)        state_d = S_CONVERT;
                else if (timeout_hit) state_d = S_A_LO;
            end
            S_CONVERT:   if (BCD_ready || timeout_hit) state_d = S_SHOW;
            S_SHOW:      if (load_ev) state_d = S_A_LO;
            default:     state_d = S_A_LO;
        endcase
    end

    // Output / datapath next values; all of them are registered below.
    always_comb begin
        operand_a_d = operand_a;
        operand_b_d = operand_b;
        result_d    = result;
        error_d     = error;
        cnt_d       = cnt_q;
        case (state_q)
            S_A_LO: if (load_ev) operand_a_d[DIP_WIDTH-1:0]        = dipswitch;
            S_A_HI: if (load_ev) operand_a_d[OP_WIDTH-1:DIP_WIDTH] = dipswitch;
            S_B_LO: if (load_ev) operand_b_d[DIP_WIDTH-1:0]        = dipswitch;
            S_B_HI: if (load_ev) operand_b_d[OP_WIDTH-1:DIP_WIDTH] = dipswitch;
            S_START: cnt_d = '0;
            S_WAIT_MULT: begin
                if (mult_done) begin
                    result_d = mult_result;
                    cnt_d    = '0;
                end else if (timeout_hit) begin
                    error_d = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_CONVERT: begin
                if (!BCD_ready && timeout_hit) error_d = 1'b1;
                cnt_d = cnt_q + CNT_W'(1);
            end
            S_SHOW: begin
                if (load_ev) begin
                    operand_a_d = '0;
                    operand_b_d = '0;
                    error_d     = 1'b0;
                end
            end
            default: ;
        endcase
        mult_start_d   = (state_d == S_START);
        result_valid_d = (state_q == S_WAIT_MULT) && (state_d == S_CONVERT);
        busy_d         = is_busy(state_d);
    end

    // Output and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            operand_a    <= '0;
            operand_b    <= '0;
            result       <= '0;
            error        <= 1'b0;
            cnt_q        <= '0;
            mult_start   <= 1'b0;
            result_valid <= 1'b0;
            busy         <= 1'b0;
        end else begin
            operand_a    <= operand_a_d;
            operand_b    <= operand_b_d;
            result       <= result_d;
            error        <= error_d;
            cnt_q        <= cnt_d;
            mult_start   <= mult_start_d;
            result_valid <= result_valid_d;
            busy         <= busy_d;
        end
    end

endmodule

// File: tb/tb_mult_sequencer.sv
// Directed testbench for mult_sequencer.
module tb_mult_sequencer;

    localparam int unsigned TO = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  dipswitch;
    logic        load_btn;
    logic        mult_done;
    logic [15:0] mult_result;
    logic        BCD_ready;
    logic [7:0]  operand_a, operand_b;
    logic        mult_start;
    logic [15:0] result;
    logic        result_valid, busy, error;
    logic [2:0]  phase;

    int n_checks = 0;
    int n_fail   = 0;

    // observations gathered by run_op
    int   obs_starts, obs_busy_low, obs_rv_cnt, obs_overlap;
    logic obs_rv_first;
    logic [2:0] obs_phase_conv;

    mult_sequencer #(.OP_WIDTH(8), .TIMEOUT_CYCLES(TO)) dut (
        .clk          (clk),
        .reset        (reset),
        .dipswitch    (dipswitch),
        .load_btn     (load_btn),
        .mult_done    (mult_done),
        .mult_result  (mult_result),
        .BCD_ready    (BCD_ready),
        .operand_a    (operand_a),
        .operand_b    (operand_b),
        .mult_start   (mult_start),
        .result       (result),
        .result_valid (result_valid),
        .busy         (busy),
        .error        (error),
        .phase        (phase)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // One button press; returns once the FSM has consumed the event.
    task automatic press(input logic [3:0] nib);
        dipswitch = nib;
        load_btn  = 1'b1;
        @(negedge clk);
        load_btn  = 1'b0;
        @(negedge clk);
    endtask

    task automatic load_ops(input logic [7:0] a, input logic [7:0] b);
        press(a[3:0]);
        press(a[7:4]);
        press(b[3:0]);
        press(b[7:4]);
    endtask

    task automatic sample();
        obs_starts += int'(mult_start);
        obs_rv_cnt += int'(result_valid);
        if (!busy) obs_busy_low++;
        if (mult_start && result_valid) obs_overlap++;
    endtask

    // Full operation: mult_done driven during the done_k-th wait cycle.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                          input logic [15:0] prod, input int done_k, input bit bcd);
        load_ops(a, b);
        obs_starts = 0; obs_busy_low = 0; obs_rv_cnt = 0; obs_overlap = 0;
        for (int k = 0; k < done_k; k++) begin
            if (k > 0) @(negedge clk);
            sample();
        end
        @(negedge clk);
        sample();
        mult_done   = 1'b1;
        mult_result = prod;
        @(negedge clk);
        mult_done      = 1'b0;
        obs_rv_first   = result_valid;
        obs_phase_conv = phase;
        sample();
        @(negedge clk);
        sample();
        if (bcd) begin
            BCD_ready = 1'b1;
            @(negedge clk);
            BCD_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (phase !== 3'd0) begin n_fail++; $display("FAIL reset_phase: got %0d expected 0", phase); end
        n_checks++; if ({operand_a, operand_b} !== 16'h0) begin n_fail++; $display("FAIL reset_operands: got %h %h expected 00 00", operand_a, operand_b); end
        n_checks++; if (result !== 16'h0) begin n_fail++; $display("FAIL reset_result: got %h expected 0000", result); end
        n_checks++; if ({mult_start, result_valid, busy, error} !== 4'b0) begin n_fail++; $display("FAIL reset_flags: got %b expected 0000", {mult_start, result_valid, busy, error}); end
    endtask

    task automatic test_basic();
        run_op(8'h03, 8'h05, 16'h000F, 4, 1'b1);
        n_checks++; if (obs_starts !== 1) begin n_fail++; $display("FAIL basic_start_count: got %0d expected 1", obs_starts); end
        n_checks++; if (result !== 16'h000F) begin n_fail++; $display("FAIL basic_result: got %h expected 000f", result); end
        n_checks++; if (obs_rv_first !== 1'b1) begin n_fail++; $display("FAIL basic_rv_latency: got %b expected 1", obs_rv_first); end
        n_checks++; if (obs_rv_cnt !== 1) begin n_fail++; $display("FAIL basic_rv_count: got %0d expected 1", obs_rv_cnt); end
        n_checks++; if (obs_overlap !== 0) begin n_fail++; $display("FAIL basic_overlap: got %0d expected 0", obs_overlap); end
        n_checks++; if (obs_phase_conv !== 3'd6) begin n_fail++; $display("FAIL basic_phase_conv: got %0d expected 6", obs_phase_conv); end
        n_checks++; if (phase !== 3'd7) begin n_fail++; $display("FAIL basic_phase_show: got %0d expected 7", phase); end
        // stray mult_done in S_SHOW must not touch result
        mult_done = 1'b1; mult_result = 16'hAAAA;
        @(negedge clk);
        mult_done = 1'b0;
        @(negedge clk);
        n_checks++; if ({result, result_valid} !== {16'h000F, 1'b0}) begin n_fail++; $display("FAIL basic_stray_done: got %h/%b expected 000f/0", result, result_valid); end
        press(4'h0);
        n_checks++; if ({phase, operand_a, operand_b} !== {3'd0, 16'h0}) begin n_fail++; $display("FAIL basic_rearm: got %0d %h %h expected 0 00 00", phase, operand_a, operand_b); end
        n_checks++; if (result !== 16'h000F) begin n_fail++; $display("FAIL basic_result_hold: got %h expected 000f", result); end
    endtask

    task automatic test_negative();
        run_op(8'hFD, 8'h05, 16'hFFF1, 4, 1'b1);
        n_checks++; if (result !== 16'hFFF1) begin n_fail++; $display("FAIL neg_result: got %h expected fff1", result); end
        n_checks++; if (error !== 1'b0) begin n_fail++; $display("FAIL neg_error: got %b expected 0", error); end
        n_checks++; if (obs_busy_low !== 0) begin n_fail++; $display("FAIL neg_busy_gap: got %0d low cycles expected 0", obs_busy_low); end
        n_checks++; if ({operand_a, operand_b, busy} !== {8'hFD, 8'h05, 1'b0}) begin n_fail++; $display("FAIL neg_show_hold: got %h %h %b expected fd 05 0", operand_a, operand_b, busy); end
        press(4'h0);
    endtask

    task automatic test_held_button();
        dipswitch = 4'h9;
        load_btn  = 1'b1;
        repeat (20) @(negedge clk);
        load_btn = 1'b0;
        @(negedge clk);
        n_checks++; if (phase !== 3'd1) begin n_fail++; $display("FAIL held_phase: got %0d expected 1", phase); end
        n_checks++; if (operand_a !== 8'h09) begin n_fail++; $display("FAIL held_operand: got %h expected 09", operand_a); end
        do_reset();
    endtask

    task automatic test_timeout();
        int cyc;
        load_ops(8'h01, 8'h02);
        cyc = 0;
        while (phase != 3'd0 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        n_checks++; if (cyc !== TO + 1) begin n_fail++; $display("FAIL timeout_cycles: got %0d expected %0d", cyc, TO + 1); end
        n_checks++; if ({error, busy} !== 2'b10) begin n_fail++; $display("FAIL timeout_flags: got %b expected 10", {error, busy}); end
        run_op(8'h02, 8'h03, 16'h0006, 4, 1'b1);
        n_checks++; if ({phase, result, error} !== {3'd7, 16'h0006, 1'b1}) begin n_fail++; $display("FAIL timeout_rerun: got %0d %h %b expected 7 0006 1", phase, result, error); end
        press(4'h0);
        n_checks++; if ({phase, error} !== {3'd0, 1'b0}) begin n_fail++; $display("FAIL timeout_clear: got %0d %b expected 0 0", phase, error); end
    endtask

    task automatic test_coincident();
        int cyc;
        run_op(8'h07, 8'h09, 16'h003F, TO, 1'b0);
        n_checks++; if ({result, error, phase} !== {16'h003F, 1'b0, 3'd6}) begin n_fail++; $display("FAIL coinc_capture: got %h %b %0d expected 003f 0 6", result, error, phase); end
        n_checks++; if (obs_rv_first !== 1'b1) begin n_fail++; $display("FAIL coinc_rv: got %b expected 1", obs_rv_first); end
        // no BCD_ready: conversion wait times out into S_SHOW
        cyc = 0;
        while (phase != 3'd7 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        n_checks++; if (cyc !== TO - 1) begin n_fail++; $display("FAIL conv_timeout_cycles: got %0d expected %0d", cyc, TO - 1); end
        n_checks++; if ({error, busy} !== 2'b10) begin n_fail++; $display("FAIL conv_timeout_flags: got %b expected 10", {error, busy}); end
        press(4'h0);
    endtask

    task automatic test_reset_mid();
        load_ops(8'h04, 8'h04);
        repeat (3) @(negedge clk);
        n_checks++; if (phase !== 3'd5) begin n_fail++; $display("FAIL mid_pre_phase: got %0d expected 5", phase); end
        reset = 1'b1;
        @(negedge clk);
        reset       = 1'b0;
        mult_done   = 1'b1;
        mult_result = 16'h1234;
        @(negedge clk);
        mult_done = 1'b0;
        @(negedge clk);
        n_checks++; if ({phase, operand_a, operand_b, result} !== {3'd0, 32'h0}) begin n_fail++; $display("FAIL mid_reset_state: got %0d %h %h %h expected 0 00 00 0000", phase, operand_a, operand_b, result); end
        n_checks++; if ({mult_start, result_valid, busy, error} !== 4'b0) begin n_fail++; $display("FAIL mid_reset_flags: got %b expected 0000", {mult_start, result_valid, busy, error}); end
    endtask

    initial begin
        reset       = 1'b1;
        dipswitch   = 4'h0;
        load_btn    = 1'b0;
        mult_done   = 1'b0;
        mult_result = 16'h0;
        BCD_ready   = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_negative();
        test_held_button();
        test_timeout();
        test_coincident();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
